// File: rtl/prom_sequencer.sv
// Purpose : walks a state machine encoded in a 256x4 registered PROM; each
//           transition reads {op,state}, then loads the returned nibble.
// Latency : 3 clocks per transition (FETCH, WAIT, DECIDE); step/done/abort
//           are registered and appear the cycle after DECIDE.
// Backpressure: none; go is only sampled in IDLE and is never queued.
//
// Ports:
//   clk        system clock (posedge)
//   reset      asynchronous active-high reset
//   go         start request, sampled in IDLE only
//   op         opcode, latched on accepted go, forms prom_addr[7:4]
//   prom_addr  {op_q, state} to the PROM
//   prom_cs    PROM read strobe, high in FETCH only
//   prom_data  PROM nibble, valid the clock after prom_cs
//   busy       high from accepted go until back in IDLE
//   step       1-clk pulse when a new state has been loaded
//   state      current state register
//   done       1-clk pulse, END_CODE read
//   abort      1-clk pulse, watchdog expired
module prom_sequencer #(
  parameter logic [3:0]  END_CODE  = 4'hF,
  parameter int unsigned MAX_STEPS = 64,
  parameter logic [3:0]  START_ST  = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [3:0] op,
  output logic [7:0] prom_addr,
  output logic       prom_cs,
  input  logic [3:0] prom_data,
  output logic       busy,
  output logic       step,
  output logic [3:0] state,
  output logic       done,
  output logic       abort
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_WAIT   = 2'd2,
    S_DECIDE = 2'd3
  } fsm_t;

  // Watchdog compare value: the transition that makes the count reach MAX_STEPS.
  localparam logic [7:0] LAST_STEP = 8'(MAX_STEPS - 1);

  fsm_t       fsm_q, fsm_d;
  logic [3:0] op_q, op_d;
  logic [3:0] state_q, state_d;
  logic [3:0] data_q, data_d;
  logic [7:0] step_cnt_q, step_cnt_d;
  logic       step_q, step_d;
  logic       done_q, done_d;
  logic       abort_q, abort_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q      <= S_IDLE;
      op_q       <= 4'h0;
      state_q    <= START_ST;
      data_q     <= 4'h0;
      step_cnt_q <= 8'd0;
      step_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      op_q       <= op_d;
      state_q    <= state_d;
      data_q     <= data_d;
      step_cnt_q <= step_cnt_d;
      step_q     <= step_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  always_comb begin
    fsm_d      = fsm_q;
    op_d       = op_q;
    state_d    = state_q;
    data_d     = data_q;
    step_cnt_d = step_cnt_q;
    // Pulses are single-cycle: cleared unless DECIDE raises them.
    step_d     = 1'b0;
    done_d     = 1'b0;
    abort_d    = 1'b0;

    case (fsm_q)
      S_IDLE: begin
        if (go) begin
          op_d       = op;
          state_d    = START_ST;
          step_cnt_d = 8'd0;
          fsm_d      = S_FETCH;
        end
      end
      S_FETCH: begin
        fsm_d = S_WAIT;
      end
      S_WAIT: begin
        // The PROM output registered at the end of FETCH is valid now.
        data_d = prom_data;
        fsm_d  = S_DECIDE;
      end
      S_DECIDE: begin
        // END_CODE is checked first so it wins over the watchdog.
        if (data_q == END_CODE) begin
          done_d = 1'b1;
          fsm_d  = S_IDLE;
        end else if (step_cnt_q == LAST_STEP) begin
          state_d = data_q;
          step_d  = 1'b1;
          abort_d = 1'b1;
          fsm_d   = S_IDLE;
        end else begin
          state_d    = data_q;
          step_d     = 1'b1;
          step_cnt_d = (step_cnt_q == 8'hFF) ? step_cnt_q : step_cnt_q + 8'd1;
          fsm_d      = S_FETCH;
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  assign prom_addr = {op_q, state_q};
  assign prom_cs   = (fsm_q == S_FETCH);
  assign busy      = (fsm_q != S_IDLE);
  assign step      = step_q;
  assign state     = state_q;
  assign done      = done_q;
  assign abort     = abort_q;

endmodule
